vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator: divides the system clock to a pixel rate, runs horizontal/vertical counters over a configurable display/front-porch/sync/back-porch geometry, and produces registered, mutually aligned sync, blanking, coordinate, line/frame-start and frame-count outputs. It sits between the board clock and the pixel renderer. It replaces the fixed 640x480 generator for any resolution and sync polarity.

## Interface
- CLK_DIV, 2, clk_in cycles per pixel (>=1; 1 = pixel every cycle)
- COORD_W, 10, width of pixel_x/pixel_y and internal counters
- HD / HFP / HSW / HBP, 640 / 16 / 96 / 48, horizontal display, front porch, sync width, back porch (pixels)
- VD / VFP / VSW / VBP, 480 / 10 / 2 / 33, vertical equivalents (lines)
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of hsync/vsync
- clk_in  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low = synchronous clear to idle
- hsync, vsync  out  1  sync pulses at configured polarity
- video_on  out  1  pixel inside display area
- p_tick  out  1  last clk_in cycle of current pixel
- pixel_x, pixel_y  out  COORD_W  current h/v count
- line_start  out  1  first cycle of h count 0
- frame_start  out  1  first cycle of (h,v)=(0,0)
- frame_cnt  out  16  completed frames, wraps

## Operation
- Divider div_cnt counts 0..CLK_DIV-1; tick = (div_cnt==CLK_DIV-1).
- On tick: h_cnt increments, wraps at HT-1 to 0 (HT=HD+HFP+HSW+HBP); on h wrap, v_cnt increments, wraps at VT-1; on v wrap, frame_cnt+1 mod 2^16.
- Decode (from h_cnt, v_cnt, div_cnt): video_on = h<HD && v<VD; hsync active for h in [HD+HFP, HD+HFP+HSW-1]; vsync active for v in [VD+VFP, VD+VFP+VSW-1]; line_start = h==0 && div_cnt==0; frame_start = line_start && v==0; p_tick = tick.
- en low: div_cnt, h_cnt, v_cnt cleared to 0 next edge; all outputs forced to idle (as reset) while low; frame_cnt holds.
- Elaboration error if HT-1 or VT-1 exceed 2^COORD_W-1, or any parameter is 0 except porches.

## Timing
- Reset values: hsync=~HSYNC_POL, vsync=~VSYNC_POL, video_on=0, p_tick=0, pixel_x=pixel_y=0, line_start=frame_start=0, frame_cnt=0; internal counters 0.
- Every output is registered once from the decode: 1 clk_in cycle latency from counter state; all outputs mutually aligned.
- First edge after reset release (en=1): frame_start=line_start=video_on=1, pixel (0,0).
- Each pixel value held exactly CLK_DIV cycles; p_tick high in its last cycle only (constant 1 when CLK_DIV=1).
- en rising: next edge behaves as first edge after reset (frame_start=1), frame_cnt unchanged.
- reset_n assertion mid-line: outputs go to reset values immediately (asynchronous).

## Structure
- Package vga_timing_pkg: default 640x480 geometry constants, HT/VT helper functions, sync-polarity constants.
- Sub-module vga_tick_div (CLK_DIV counter, tick and first-cycle flags); counters, decode and output register in top.

## Test plan
- Small geometry HD=8,HFP=2,HSW=3,HBP=3, VD=4,VFP=1,VSW=2,VBP=1, CLK_DIV=2: pixel_x sequence 0..15 each held 2 cycles, hsync active exactly 6 cycles starting when pixel_x=10.
- Same config: vsync active exactly for pixel_y=5,6 (2*32 cycles); video_on count per frame = 32 pixels; frame_start every 256 cycles; frame_cnt=3 after 768 cycles.
- CLK_DIV=1, HSYNC_POL=1: p_tick constant 1 after reset, hsync high-active, line_start every 16 cycles.
- Reset check: reset_n low with en=1 -> all outputs at reset values; release -> first cycle shows frame_start=1, (0,0), video_on=1.
- en dropped at pixel (5,2) -> next cycle outputs idle, frame_cnt held; en raised -> next cycle frame_start=1, (0,0).
- Async reset asserted mid-frame between clock edges -> outputs reset before the next clk_in edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Purpose: shared geometry defaults, sync-polarity constants, the decoded-flag
//          struct and raster-total helpers for the VGA timing generator.
// Ports:   none (package).
package vga_timing_pkg;

  // Default 640x480@60 geometry (pixels / lines)
  localparam int VGA_HD  = 640;
  localparam int VGA_HFP = 16;
  localparam int VGA_HSW = 96;
  localparam int VGA_HBP = 48;
  localparam int VGA_VD  = 480;
  localparam int VGA_VFP = 10;
  localparam int VGA_VSW = 2;
  localparam int VGA_VBP = 33;

  // Active level of a sync pulse
  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;

  // Single-bit raster flags, decoded then registered together
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic p_tick;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  function automatic int h_total(input int hd, input int hfp, input int hsw, input int hbp);
    return hd + hfp + hsw + hbp;
  endfunction

  function automatic int v_total(input int vd, input int vfp, input int vsw, input int vbp);
    return vd + vfp + vsw + vbp;
  endfunction

  // True when a terminal count fits in an unsigned counter of width w
  function automatic bit count_fits(input int last, input int w);
    return longint'(last) <= ((longint'(1) << w) - 1);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose: raster timing bundle from the generator (master) to the renderer (slave).
// Signals: hsync/vsync/video_on/p_tick/line_start/frame_start flags,
//          pixel_x/pixel_y coordinates (COORD_W), frame_cnt (16-bit).
interface vga_timing_gen_if #(
  parameter int COORD_W = 10
);
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic               p_tick;
  logic               line_start;
  logic               frame_start;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [15:0]        frame_cnt;

  modport master (
    output hsync, vsync, video_on, p_tick, line_start, frame_start,
    output pixel_x, pixel_y, frame_cnt
  );

  modport slave (
    input hsync, vsync, video_on, p_tick, line_start, frame_start,
    input pixel_x, pixel_y, frame_cnt
  );
endinterface

// File: rtl/vga_tick_div.sv
// Purpose: divides clk_in down to the pixel rate; flags the first and last
//          clk_in cycle of each pixel. Combinational flags from the counter
//          state (0 cycles); free-running, no backpressure; en low clears.
// Ports:   clk_in, reset_n (async active-low), en; tick (last cycle), first (first cycle).
module vga_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic en,
  output logic tick,
  output logic first
);

  // A divide-by-1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (!en) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick  = (div_cnt == DIV_LAST);
  assign first = (div_cnt == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing generator (h/v counters, sync,
//          blanking, coordinates, line/frame start, frame count).
//          Latency: every output is one registered stage after the counter state.
//          Backpressure: none, free-running; en low clears counters and idles outputs.
// Ports:   clk_in, reset_n (async active-low), en; vga (vga_timing_gen_if.master).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int COORD_W   = 10,
  parameter int HD        = VGA_HD,
  parameter int HFP       = VGA_HFP,
  parameter int HSW       = VGA_HSW,
  parameter int HBP       = VGA_HBP,
  parameter int VD        = VGA_VD,
  parameter int VFP       = VGA_VFP,
  parameter int VSW       = VGA_VSW,
  parameter int VBP       = VGA_VBP,
  parameter bit HSYNC_POL = SYNC_ACT_LOW,
  parameter bit VSYNC_POL = SYNC_ACT_LOW
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  vga_timing_gen_if.master vga
);

  localparam int HT = h_total(HD, HFP, HSW, HBP);
  localparam int VT = v_total(VD, VFP, VSW, VBP);

  // Geometry sanity: porches may be zero, nothing else may.
  if (CLK_DIV < 1 || COORD_W < 1 || HD < 1 || HSW < 1 || VD < 1 || VSW < 1) begin : g_bad_param
    $error("vga_timing_gen: divider, width, display or sync parameter is zero");
  end
  if (!count_fits(HT - 1, COORD_W)) begin : g_bad_ht
    $error("vga_timing_gen: horizontal total does not fit COORD_W");
  end
  if (!count_fits(VT - 1, COORD_W)) begin : g_bad_vt
    $error("vga_timing_gen: vertical total does not fit COORD_W");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(HT - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(VT - 1);
  localparam logic [COORD_W-1:0] H_DISP   = COORD_W'(HD);
  localparam logic [COORD_W-1:0] V_DISP   = COORD_W'(VD);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(HD + HFP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(HD + HFP + HSW - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(VD + VFP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(VD + VFP + VSW - 1);

  localparam vga_flags_t FLAGS_IDLE = '{
    hsync:       ~HSYNC_POL,
    vsync:       ~VSYNC_POL,
    video_on:    1'b0,
    p_tick:      1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic               tick;
  logic               first;
  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic [15:0]        frame_cnt_r;
  vga_flags_t         dec;
  vga_flags_t         flags_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [15:0]        frame_cnt_q;

  vga_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .en      (en),
    .tick    (tick),
    .first   (first)
  );

  // Raster counters. frame_cnt_r steps on the same edge that returns the
  // counters to (0,0), so the registered copy changes together with frame_start.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt_r <= '0;
    end else if (!en) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt       <= '0;
          frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
          v_cnt <= v_cnt + COORD_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + COORD_W'(1);
      end
    end
  end

  // Decode from the current counter state
  always_comb begin
    logic ls;
    ls              = (h_cnt == '0) && first;
    dec             = FLAGS_IDLE;
    dec.video_on    = (h_cnt < H_DISP) && (v_cnt < V_DISP);
    dec.hsync       = ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
    dec.vsync       = ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
    dec.p_tick      = tick;
    dec.line_start  = ls;
    dec.frame_start = ls && (v_cnt == '0);
  end

  // Single output register stage keeps every output mutually aligned.
  // frame_cnt keeps tracking the (held) internal count while en is low.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      flags_q     <= FLAGS_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_r;
      if (!en) begin
        flags_q <= FLAGS_IDLE;
        x_q     <= '0;
        y_q     <= '0;
      end else begin
        flags_q <= dec;
        x_q     <= h_cnt;
        y_q     <= v_cnt;
      end
    end
  end

  assign vga.hsync       = flags_q.hsync;
  assign vga.vsync       = flags_q.vsync;
  assign vga.video_on    = flags_q.video_on;
  assign vga.p_tick      = flags_q.p_tick;
  assign vga.line_start  = flags_q.line_start;
  assign vga.frame_start = flags_q.frame_start;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule
